tx_hdr_gen: RTL and testbench

- Transmit-side counterpart of the receive destination-address checker.
- On a start request, emits the Ethernet frame header on a 4-bit MII-style nibble bus: preamble, SFD, destination address, source address (the NIC's own MAC) and type/length.
- Then signals the payload sender to take over the bus.
- Sits between the TX control FSM and the TX nibble mux feeding the PHY.

---
 rtl/tx_pkg.sv | 29 ++
 rtl/tx_nib_sel.sv | 24 ++
 rtl/tx_hdr_gen.sv | 125 ++++++++++++
 tb/tb_tx_hdr_gen.sv | 132 +++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared TX header constants, state encoding and per-state nibble counts.
// MAC_ADDR is the NIC's own address, also used by the receive address checker.
package tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DA,
    ST_SA,
`ifdef TX_VLAN_EN
    ST_VLAN,
`endif
    ST_TYPE
  } tx_state_t;

  localparam int PRE_LEN  = 15;
  localparam int SFD_LEN  = 1;
  localparam int DA_LEN   = 12;
  localparam int SA_LEN   = 12;
  localparam int VLAN_LEN = 8;
  localparam int TYPE_LEN = 4;

  localparam logic [3:0]  PRE_NIB   = 4'h5;
  localparam logic [3:0]  SFD_NIB   = 4'hD;
  localparam logic [15:0] VLAN_TPID = 16'h8100;
  localparam logic [47:0] MAC_ADDR  = 48'h00_0C_29_4A_35_50;

endpackage

// File: rtl/tx_nib_sel.sv
// Combinational pick of nibble idx from a byte-ordered field, MSB byte first, low nibble first.
// Zero latency; indices past the field width return 0.
module tx_nib_sel #(
  parameter int W = 48
) (
  input  logic [W-1:0] field,
  input  logic [3:0]   idx,
  output logic [3:0]   nib
);

  logic [3:0] nibs [16];

  // Even index -> low half of byte idx/2, odd index -> high half.
  for (genvar k = 0; k < 16; k++) begin : g_nib
    if (k < W / 4) begin : g_on
      assign nibs[k] = field[W - 8*(k/2) - ((k % 2) != 0 ? 1 : 5) -: 4];
    end else begin : g_off
      assign nibs[k] = 4'h0;
    end
  end

  assign nib = nibs[idx];

endmodule

// File: rtl/tx_hdr_gen.sv
// Emits preamble/SFD/DA/SA/[VLAN]/TYPE as MII nibbles; first nibble 1 cycle after start, no backpressure.
// Optional VLAN tag insertion is enabled by defining TX_VLAN_EN.
module tx_hdr_gen import tx_pkg::*; #(
  parameter int          DATA_WITCH   = 4,
  parameter int          DSTADDR_SIZE = 48,
  parameter logic [47:0] MAC_ADDR     = tx_pkg::MAC_ADDR,
  parameter int          PRE_NIBS     = PRE_LEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    I_start,
  input  logic [DSTADDR_SIZE-1:0] I_da,
  input  logic [15:0]             I_type,
`ifdef TX_VLAN_EN
  input  logic [15:0]             I_vlan_tci,
`endif
  output logic                    O_busy,
  output logic                    O_tx_en,
  output logic [DATA_WITCH-1:0]   O_txd,
  output logic                    O_hdr_done
);

  tx_state_t              state, nxt_state;
  logic [3:0]             cnt, nxt_cnt;
  logic [DSTADDR_SIZE-1:0] da_q;
  logic [15:0]            type_q;
  logic [3:0]             da_nib, sa_nib, type_nib, nxt_nib;

  function automatic logic [3:0] last_idx(tx_state_t s);
    case (s)
      ST_PRE:  return 4'(PRE_NIBS - 1);
      ST_SFD:  return 4'(SFD_LEN - 1);
      ST_DA:   return 4'(DA_LEN - 1);
      ST_SA:   return 4'(SA_LEN - 1);
`ifdef TX_VLAN_EN
      ST_VLAN: return 4'(VLAN_LEN - 1);
`endif
      default: return 4'(TYPE_LEN - 1);
    endcase
  endfunction

  tx_nib_sel #(.W(DSTADDR_SIZE)) u_da_sel   (.field(da_q),     .idx(nxt_cnt), .nib(da_nib));
  tx_nib_sel #(.W(48))           u_sa_sel   (.field(MAC_ADDR), .idx(nxt_cnt), .nib(sa_nib));
  tx_nib_sel #(.W(16))           u_type_sel (.field(type_q),   .idx(nxt_cnt), .nib(type_nib));

`ifdef TX_VLAN_EN
  logic [15:0] tci_q;
  logic [3:0]  vlan_nib;
  tx_nib_sel #(.W(32)) u_vlan_sel (.field({VLAN_TPID, tci_q}), .idx(nxt_cnt), .nib(vlan_nib));
`endif

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    if (state == ST_IDLE) begin
      if (I_start) begin
        nxt_state = ST_PRE;
        nxt_cnt   = 4'd0;
      end
    end else if (cnt == last_idx(state)) begin
      nxt_cnt = 4'd0;
      case (state)
        ST_PRE:  nxt_state = ST_SFD;
        ST_SFD:  nxt_state = ST_DA;
        ST_DA:   nxt_state = ST_SA;
`ifdef TX_VLAN_EN
        ST_SA:   nxt_state = ST_VLAN;
        ST_VLAN: nxt_state = ST_TYPE;
`else
        ST_SA:   nxt_state = ST_TYPE;
`endif
        default: nxt_state = ST_IDLE;
      endcase
    end else begin
      nxt_cnt = cnt + 4'd1;
    end
  end

  // Outputs are registered from the next state so the nibble lines up with tx_en.
  always_comb begin
    nxt_nib = 4'h0;
    case (nxt_state)
      ST_PRE:  nxt_nib = PRE_NIB;
      ST_SFD:  nxt_nib = SFD_NIB;
      ST_DA:   nxt_nib = da_nib;
      ST_SA:   nxt_nib = sa_nib;
`ifdef TX_VLAN_EN
      ST_VLAN: nxt_nib = vlan_nib;
`endif
      ST_TYPE: nxt_nib = type_nib;
      default: nxt_nib = 4'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      da_q       <= '0;
      type_q     <= '0;
`ifdef TX_VLAN_EN
      tci_q      <= '0;
`endif
      O_busy     <= 1'b0;
      O_tx_en    <= 1'b0;
      O_txd      <= '0;
      O_hdr_done <= 1'b0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      if (state == ST_IDLE && I_start) begin
        da_q   <= I_da;
        type_q <= I_type;
`ifdef TX_VLAN_EN
        tci_q  <= I_vlan_tci;
`endif
      end
      O_busy     <= (nxt_state != ST_IDLE);
      O_tx_en    <= (nxt_state != ST_IDLE);
      O_txd      <= DATA_WITCH'(nxt_nib);
      O_hdr_done <= (nxt_state == ST_TYPE) && (nxt_cnt == 4'(TYPE_LEN - 1));
    end
  end

endmodule

// File: tb/tb_tx_hdr_gen.sv
// Bench for tx_hdr_gen: expected nibbles come from the header's byte layout on the wire.
module tb_tx_hdr_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        I_start;
  logic [47:0] I_da;
  logic [15:0] I_type;
  logic [15:0] tci;
  logic        O_busy, O_tx_en, O_hdr_done;
  logic [3:0]  O_txd;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q [$];

  localparam logic [47:0] OWN_MAC = 48'h000C294A3550;

  always #5 clk = ~clk;

  tx_hdr_gen dut (
    .clk(clk), .rst(rst), .I_start(I_start), .I_da(I_da), .I_type(I_type),
`ifdef TX_VLAN_EN
    .I_vlan_tci(tci),
`endif
    .O_busy(O_busy), .O_tx_en(O_tx_en), .O_txd(O_txd), .O_hdr_done(O_hdr_done)
  );

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tx_en"}, O_tx_en, 0);
    chk({tag, "_txd"},   O_txd, 0);
    chk({tag, "_busy"},  O_busy, 0);
    chk({tag, "_done"},  O_hdr_done, 0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    exp_q.push_back(b[3:0]);
    exp_q.push_back(b[7:4]);
  endtask

  task automatic build_model(input logic [47:0] da, input logic [15:0] typ, input logic [15:0] vt);
    exp_q.delete();
    repeat (7) push_byte(8'h55);
    push_byte(8'hD5);
    for (int b = 5; b >= 0; b--) push_byte(da[8*b +: 8]);
    for (int b = 5; b >= 0; b--) push_byte(OWN_MAC[8*b +: 8]);
`ifdef TX_VLAN_EN
    push_byte(8'h81); push_byte(8'h00);
    push_byte(vt[15:8]); push_byte(vt[7:0]);
`endif
    push_byte(typ[15:8]);
    push_byte(typ[7:0]);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the idle gap cycle.
  task automatic send(input logic [47:0] da, input logic [15:0] typ, input logic [15:0] vt,
                      input int glitch_at, input int abort_at);
    build_model(da, typ, vt);
    I_da = da; I_type = typ; tci = vt; I_start = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      I_start = (i == glitch_at);
      I_da    = {16'($urandom), 32'($urandom)};
      I_type  = 16'($urandom);
      tci     = 16'($urandom);
      chk($sformatf("tx_en[%0d]", i), O_tx_en, 1);
      chk($sformatf("txd[%0d]", i), O_txd, exp_q[i]);
      chk($sformatf("busy[%0d]", i), O_busy, 1);
      chk($sformatf("done[%0d]", i), O_hdr_done, 48'(i == exp_q.size() - 1));
      if (i == abort_at) return;
    end
    I_start = 1'b0;
    @(negedge clk);
    chk_idle("gap");
  endtask

  initial begin
    rst = 1'b0; I_start = 1'b0; I_da = '0; I_type = '0; tci = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle("in_reset");
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk_idle($sformatf("idle%0d", c));
    end

    send(48'h0123456789AB, 16'h0800, 16'h6005, -1, -1);
    chk("hdr_len", 48'(exp_q.size()),
`ifdef TX_VLAN_EN
        52
`else
        44
`endif
    );
    send(48'h0123456789AB, 16'h0800, 16'h6005, 20, -1);
    send(48'hFFFFFFFFFFFF, 16'h86DD, 16'h0001, -1, -1);

    send({16'($urandom), 32'($urandom)}, 16'($urandom), 16'($urandom), -1, 30);
    #2 rst = 1'b1;
    #1 chk_idle("async_rst");
    @(negedge clk);
    chk_idle("rst_held");
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk_idle($sformatf("post_rst%0d", c));
    end
    send({16'($urandom), 32'($urandom)}, 16'($urandom), 16'($urandom), -1, -1);

    for (int f = 0; f < 5; f++) begin
      send({16'($urandom), 32'($urandom)}, 16'($urandom), 16'($urandom),
           int'($urandom_range(0, 40)), -1);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk_idle("rand_gap");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
